// File: rtl/ibex_mult_pext_sequencer_if.sv
// ibex_mult_pext_sequencer_if
//   Groups the request/control and datapath strobe signals of the P-ext
//   multiplier phase sequencer into one bundle.
//   Request side (driven by ex stage / datapath, read by sequencer):
//     mult_en_i, kill_i, mult_mode_i[1:0], cycle_count_i[1:0],
//     accum_sub_i[1:0], add_mode_i[1:0], sat_i, vxsat_clr_i
//   Control side (driven by sequencer):
//     phase_o[1:0], mult_mode_o[1:0], acc_en_o, acc_sel_o, sum2_add_o,
//     sum_sub_o, rd_add_o, rd_sub_o, valid_o, busy_o, ovf_o
//   modport master: ex-stage / datapath view
//   modport slave : sequencer view
interface ibex_mult_pext_sequencer_if;
  logic       mult_en_i;
  logic       kill_i;
  logic [1:0] mult_mode_i;
  logic [1:0] cycle_count_i;
  logic [1:0] accum_sub_i;
  logic [1:0] add_mode_i;
  logic       sat_i;
  logic       vxsat_clr_i;

  logic [1:0] phase_o;
  logic [1:0] mult_mode_o;
  logic       acc_en_o;
  logic       acc_sel_o;
  logic       sum2_add_o;
  logic       sum_sub_o;
  logic       rd_add_o;
  logic       rd_sub_o;
  logic       valid_o;
  logic       busy_o;
  logic       ovf_o;

  modport master (
    output mult_en_i, kill_i, mult_mode_i, cycle_count_i, accum_sub_i,
           add_mode_i, sat_i, vxsat_clr_i,
    input  phase_o, mult_mode_o, acc_en_o, acc_sel_o, sum2_add_o,
           sum_sub_o, rd_add_o, rd_sub_o, valid_o, busy_o, ovf_o
  );

  modport slave (
    input  mult_en_i, kill_i, mult_mode_i, cycle_count_i, accum_sub_i,
           add_mode_i, sat_i, vxsat_clr_i,
    output phase_o, mult_mode_o, acc_en_o, acc_sel_o, sum2_add_o,
           sum_sub_o, rd_add_o, rd_sub_o, valid_o, busy_o, ovf_o
  );
endinterface

// File: rtl/ibex_mult_pext_sequencer.sv
// ibex_mult_pext_sequencer
//   Steps the shared P-ext multiplier through 1, 2 or 3 partial-product
//   phases and drives the accumulator/adder controls for each phase.
//   Phase 0 executes combinationally in the request cycle; valid_o is raised
//   in the final phase.
// Ports
//   clk_i   : clock
//   rst_ni  : synchronous reset, active-low
//   bus     : ibex_mult_pext_sequencer_if.slave (request in, strobes out)
// Parameters
//   RegisterCtrl : 1 = mode/accum_sub/add_mode captured at phase 0 and held
//                  until the op ends; 0 = taken live from the inputs
// Build option
//   IBEX_PEXT_VXSAT_EN : enables the sticky saturation flag ovf_o
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no op in flight; phase 0 of a new request executes here
// PH1   | phase 1 executing (final phase for 2-cycle ops)
// PH2   | phase 2 executing (always final)
module ibex_mult_pext_sequencer #(
  parameter bit RegisterCtrl = 1'b1
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  ibex_mult_pext_sequencer_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PH1  = 2'b01;
  localparam logic [1:0] S_PH2  = 2'b10;

  localparam logic [1:0] M32X32 = 2'b11;

  logic [1:0] r_state;
  logic [1:0] r_mode;
  logic [1:0] r_accum_sub;
  logic [1:0] r_add_mode;
  logic       r_three;

  logic       w_active;
  logic       w_start;
  logic       w_final;
  logic       w_fin_act;
  logic       w_use_reg;
  logic [1:0] w_phase;
  logic [1:0] w_mode;
  logic [1:0] w_as;
  logic [1:0] w_am;
  logic [1:0] w_state_nxt;

  // A phase executes whenever a live, unkilled request is present. Gating with
  // rst_ni keeps every strobe quiet during a reset cycle.
  assign w_active = rst_ni & bus.mult_en_i & ~bus.kill_i;
  assign w_start  = w_active & (r_state == S_IDLE);

  always_comb begin
    w_phase = 2'd0;
    w_final = (bus.cycle_count_i == 2'b00);
    case (r_state)
      S_PH1: begin
        w_phase = 2'd1;
        w_final = ~r_three;
      end
      S_PH2: begin
        w_phase = 2'd2;
        w_final = 1'b1;
      end
      default: begin
        w_phase = 2'd0;
        w_final = (bus.cycle_count_i == 2'b00);
      end
    endcase
  end

  // Phase 0 always sees the live inputs; later phases use the captured copy
  // when RegisterCtrl is set.
  assign w_use_reg = RegisterCtrl && (r_state != S_IDLE);
  assign w_mode    = w_use_reg ? r_mode      : bus.mult_mode_i;
  assign w_as      = w_use_reg ? r_accum_sub : bus.accum_sub_i;
  assign w_am      = w_use_reg ? r_add_mode  : bus.add_mode_i;

  // Any non-active cycle (kill, dropped request, no request) returns to IDLE.
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_active && !w_final) begin
      w_state_nxt = (r_state == S_PH1) ? S_PH2 : S_PH1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_accum_sub <= 2'b00;
      r_add_mode  <= 2'b00;
      r_three     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_mode      <= bus.mult_mode_i;
        r_accum_sub <= bus.accum_sub_i;
        r_add_mode  <= bus.add_mode_i;
        // cycle_count 10 behaves as 01, so only 11 needs the extra phase
        r_three     <= (bus.cycle_count_i == 2'b11);
      end
    end
  end

  assign w_fin_act = w_active & w_final;

  assign bus.phase_o     = w_active ? w_phase : 2'd0;
  assign bus.mult_mode_o = w_active ? w_mode  : M32X32;
  assign bus.acc_en_o    = w_active & ~w_final;
  assign bus.acc_sel_o   = w_active & (r_state != S_IDLE);
  assign bus.sum2_add_o  = w_fin_act & w_am[0];
  assign bus.sum_sub_o   = w_fin_act & w_as[1];
  assign bus.rd_add_o    = w_fin_act & w_am[1];
  assign bus.rd_sub_o    = w_fin_act & w_as[0];
  assign bus.valid_o     = w_fin_act;
  assign bus.busy_o      = (r_state != S_IDLE);

`ifdef IBEX_PEXT_VXSAT_EN
  logic r_ovf;

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (bus.sat_i && w_active) begin
      r_ovf <= 1'b1;
    end else if (bus.vxsat_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.ovf_o = r_ovf;
`else
  logic w_unused_sat;
  assign w_unused_sat = bus.sat_i ^ bus.vxsat_clr_i;
  assign bus.ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// tb_ibex_mult_pext_sequencer
//   Directed bench for the P-ext multiplier phase sequencer. A phase-counting
//   model predicts every output each cycle; literal checks pin key cycles.
module tb_ibex_mult_pext_sequencer;

  localparam bit RC = 1'b1;
`ifdef IBEX_PEXT_VXSAT_EN
  localparam logic FEAT = 1'b1;
`else
  localparam logic FEAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_mult_pext_sequencer_if bus ();

  ibex_mult_pext_sequencer #(.RegisterCtrl(RC)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: op described as "phase k of N" ----------------
  int         m_ph = 0;     // index of the phase to execute next; 0 = no op in flight
  int         m_n  = 1;
  logic [1:0] m_mode = 2'b00, m_as = 2'b00, m_am = 2'b00;
  logic       m_ovf = 1'b0;

  int         ph, n;
  bit         act, fin;
  logic [1:0] md, eas, eam;

  function automatic int n_of(input logic [1:0] cc);
    if (cc == 2'b00) return 1;
    if (cc == 2'b11) return 3;
    return 2;
  endfunction

  always @(negedge clk) begin
    act = rst_n && bus.mult_en_i && !bus.kill_i;
    if (m_ph == 0) begin
      ph = 0; n = n_of(bus.cycle_count_i);
      md = bus.mult_mode_i; eas = bus.accum_sub_i; eam = bus.add_mode_i;
    end else begin
      ph = m_ph; n = m_n;
      md  = RC ? m_mode : bus.mult_mode_i;
      eas = RC ? m_as   : bus.accum_sub_i;
      eam = RC ? m_am   : bus.add_mode_i;
    end
    fin = act && (ph == n - 1);

    if (started) begin
      chk("cyc_valid",    bus.valid_o,    fin);
      chk("cyc_acc_en",   bus.acc_en_o,   act && (ph < n - 1));
      chk("cyc_acc_sel",  bus.acc_sel_o,  act && (ph > 0));
      chk("cyc_sum2_add", bus.sum2_add_o, fin && eam[0]);
      chk("cyc_sum_sub",  bus.sum_sub_o,  fin && eas[1]);
      chk("cyc_rd_add",   bus.rd_add_o,   fin && eam[1]);
      chk("cyc_rd_sub",   bus.rd_sub_o,   fin && eas[0]);
      chk("cyc_mode",     bus.mult_mode_o, act ? md : 2'b11);
      chk("cyc_busy",     bus.busy_o,     m_ph != 0);
      chk("cyc_ovf",      bus.ovf_o,      m_ovf);
      if (act) chk("cyc_phase", bus.phase_o, ph[1:0]);
    end

    // advance to the state after the coming rising edge
    if (!rst_n) begin
      m_ph = 0; m_ovf = 1'b0;
      m_mode = 2'b00; m_as = 2'b00; m_am = 2'b00;
    end else begin
      if (act) begin
        if (ph == 0) begin
          m_n = n; m_mode = bus.mult_mode_i; m_as = bus.accum_sub_i; m_am = bus.add_mode_i;
        end
        m_ph = fin ? 0 : ph + 1;
      end else begin
        m_ph = 0;
      end
      if (FEAT) begin
        if (act && bus.sat_i) m_ovf = 1'b1;
        else if (bus.vxsat_clr_i) m_ovf = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rst, input logic en, input logic kill,
                     input logic [1:0] mode, input logic [1:0] cc,
                     input logic [1:0] as_, input logic [1:0] am,
                     input logic sat, input logic clr);
    @(posedge clk);
    #1;
    rst_n             = rst;
    bus.mult_en_i     = en;
    bus.kill_i        = kill;
    bus.mult_mode_i   = mode;
    bus.cycle_count_i = cc;
    bus.accum_sub_i   = as_;
    bus.add_mode_i    = am;
    bus.sat_i         = sat;
    bus.vxsat_clr_i   = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 0, 0);
  endtask

  initial begin
    bus.mult_en_i = 0; bus.kill_i = 0; bus.mult_mode_i = 0; bus.cycle_count_i = 0;
    bus.accum_sub_i = 0; bus.add_mode_i = 0; bus.sat_i = 0; bus.vxsat_clr_i = 0;

    // reset
    cyc(0, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 0, 0);
    started = 1'b1;
    cyc(0, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 0, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_busy",  bus.busy_o,  0);
    chk("rst_mode",  bus.mult_mode_o, 2'b11);
    chk("rst_acc_en", bus.acc_en_o, 0);
    chk("rst_ovf",   bus.ovf_o,   0);

    // single-cycle op
    cyc(1, 1, 0, 2'd0, 2'b00, 2'b00, 2'b11, 0, 0);
    chk("n1_valid", bus.valid_o, 1);
    chk("n1_phase", bus.phase_o, 0);
    chk("n1_rd_add", bus.rd_add_o, 1);
    chk("n1_sum2_add", bus.sum2_add_o, 1);
    chk("n1_busy", bus.busy_o, 0);
    idle();

    // three-cycle op, then back-to-back two-cycle op
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b10, 2'b01, 0, 0);
    chk("n3_c0_phase", bus.phase_o, 0);  chk("n3_c0_acc_en", bus.acc_en_o, 1);
    chk("n3_c0_sel", bus.acc_sel_o, 0);  chk("n3_c0_valid", bus.valid_o, 0);
    chk("n3_c0_busy", bus.busy_o, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b10, 2'b01, 0, 0);
    chk("n3_c1_phase", bus.phase_o, 1);  chk("n3_c1_acc_en", bus.acc_en_o, 1);
    chk("n3_c1_sel", bus.acc_sel_o, 1);  chk("n3_c1_valid", bus.valid_o, 0);
    chk("n3_c1_busy", bus.busy_o, 1);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b10, 2'b01, 0, 0);
    chk("n3_c2_phase", bus.phase_o, 2);  chk("n3_c2_acc_en", bus.acc_en_o, 0);
    chk("n3_c2_sel", bus.acc_sel_o, 1);  chk("n3_c2_valid", bus.valid_o, 1);
    chk("n3_c2_busy", bus.busy_o, 1);    chk("n3_c2_sum_sub", bus.sum_sub_o, 1);
    chk("n3_c2_sum2_add", bus.sum2_add_o, 1); chk("n3_c2_rd_add", bus.rd_add_o, 0);
    chk("n3_c2_mode", bus.mult_mode_o, 2'b11);
    cyc(1, 1, 0, 2'd1, 2'b01, 2'b00, 2'b10, 0, 0);
    chk("b2b_busy", bus.busy_o, 0); chk("b2b_acc_en", bus.acc_en_o, 1);
    chk("b2b_valid0", bus.valid_o, 0);
    cyc(1, 1, 0, 2'd1, 2'b01, 2'b00, 2'b10, 0, 0);
    chk("b2b_valid1", bus.valid_o, 1); chk("b2b_rd_add", bus.rd_add_o, 1);
    idle();

    // kill during PH1
    cyc(1, 1, 0, 2'd2, 2'b11, 2'b00, 2'b00, 0, 0);
    cyc(1, 1, 1, 2'd2, 2'b11, 2'b00, 2'b00, 0, 0);
    chk("kill_valid", bus.valid_o, 0); chk("kill_acc_en", bus.acc_en_o, 0);
    chk("kill_busy", bus.busy_o, 1);
    cyc(1, 1, 0, 2'd0, 2'b00, 2'b00, 2'b11, 0, 0);
    chk("kill_next_busy", bus.busy_o, 0); chk("kill_next_valid", bus.valid_o, 1);
    idle();

    // cycle_count 10 acts as 2 cycles
    cyc(1, 1, 0, 2'd2, 2'b10, 2'b00, 2'b00, 0, 0);
    chk("cc10_valid0", bus.valid_o, 0);
    cyc(1, 1, 0, 2'd2, 2'b10, 2'b00, 2'b00, 0, 0);
    chk("cc10_valid1", bus.valid_o, 1); chk("cc10_phase", bus.phase_o, 1);
    idle();

    // captured controls hold after phase 0
    cyc(1, 1, 0, 2'd1, 2'b01, 2'b01, 2'b10, 0, 0);
    chk("rc_mode0", bus.mult_mode_o, 2'd1);
    cyc(1, 1, 0, 2'd2, 2'b00, 2'b00, 2'b00, 0, 0);
    chk("rc_valid", bus.valid_o, 1); chk("rc_mode1", bus.mult_mode_o, 2'd1);
    chk("rc_rd_add", bus.rd_add_o, 1); chk("rc_rd_sub", bus.rd_sub_o, 1);
    chk("rc_sum2_add", bus.sum2_add_o, 0);
    idle();

    // kill in IDLE with request
    cyc(1, 1, 1, 2'd0, 2'b00, 2'b00, 2'b11, 0, 0);
    chk("kidle_valid", bus.valid_o, 0); chk("kidle_mode", bus.mult_mode_o, 2'b11);
    idle();
    chk("kidle_busy", bus.busy_o, 0);

    // request dropped in PH1
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b00, 0, 0);
    cyc(1, 0, 0, 2'd3, 2'b11, 2'b00, 2'b00, 0, 0);
    chk("drop_valid", bus.valid_o, 0);
    idle();
    chk("drop_busy", bus.busy_o, 0);

    // reset mid-op
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(0, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    chk("rmid_valid", bus.valid_o, 0); chk("rmid_mode", bus.mult_mode_o, 2'b11);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    chk("rmid_busy", bus.busy_o, 0); chk("rmid_phase", bus.phase_o, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b11, 0, 0);
    chk("rmid_valid2", bus.valid_o, 1);
    idle();

    // sticky saturation flag
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b00, 1, 0);
    chk("sat_before", bus.ovf_o, 0);
    cyc(1, 1, 0, 2'd3, 2'b11, 2'b00, 2'b00, 1, 1);
    chk("sat_set", bus.ovf_o, FEAT);
    idle();
    chk("sat_set_wins", bus.ovf_o, FEAT);
    cyc(1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 1, 1);
    chk("sat_hold", bus.ovf_o, FEAT);
    cyc(1, 0, 0, 2'd0, 2'b00, 2'b00, 2'b00, 1, 0);
    chk("sat_cleared", bus.ovf_o, 0);
    idle();
    chk("sat_idle_noset", bus.ovf_o, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
